// File: rtl/yrv_stim_seq.sv
// Stimulus sequencer for yrv_soc: CPU reset sequence plus per-channel LFSR port data.
// Optional interrupt pulse generation when YRV_STIM_IRQ_EN is defined.
module yrv_stim_seq #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned PORT_WIDTH = 16,
  parameter int unsigned PRE_CYCLES = 10,
  parameter int unsigned RST_CYCLES = 10,
  parameter logic [31:0] RUN_CYCLES = 32'd10000,
  parameter logic [31:0] SEED       = 32'h1
`ifdef YRV_STIM_IRQ_EN
  ,
  parameter int unsigned IRQ_PERIOD = 1000,
  parameter logic [31:0] NMI_AT     = 32'd0
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            rand_en,
  input  logic                            hold,
  output logic                            cpu_resetb,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_in,
  output logic                            busy,
  output logic                            done,
`ifdef YRV_STIM_IRQ_EN
  output logic                            ei_req,
  output logic                            nmi_req,
`endif
  output logic [31:0]                     cycle_cnt
);

  typedef enum logic [2:0] {StIdle, StPre, StAssert, StRun, StDone} state_e;

  localparam logic [31:0] PreLast = 32'(PRE_CYCLES - 1);
  localparam logic [31:0] RstLast = 32'(RST_CYCLES - 1);

  // Seeds are spread by the golden-ratio constant so channels decorrelate.
  function automatic logic [31:0] seed_of(input int unsigned k);
    logic [31:0] s;
    s = SEED + 32'(k) * 32'h9E3779B9;
    return (s == 32'd0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  state_e                            state_q, state_d;
  logic [31:0]                       phase_q, phase_d;
  logic [31:0]                       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0][31:0]        lfsr_q, lfsr_d;
  logic [NUM_PORTS*PORT_WIDTH-1:0]   port_q, port_d;
  logic                              cpu_resetb_q, busy_q, done_q;
  logic                              start_ok;

  assign start_ok = start && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    port_d  = port_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StPre;
          phase_d = 32'd0;
          cnt_d   = 32'd0;
          for (int unsigned k = 0; k < NUM_PORTS; k++) lfsr_d[k] = seed_of(k);
        end
      end
      StPre: begin
        if (phase_q == PreLast) begin
          state_d = StAssert;
          phase_d = 32'd0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      StAssert: begin
        if (phase_q == RstLast) begin
          state_d = StRun;
          phase_d = 32'd0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      StRun: begin
        if (!hold) begin
          cnt_d = cnt_q + 32'd1;
          if (rand_en) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
              lfsr_d[k] = lfsr_step(lfsr_q[k]);
              port_d[k*PORT_WIDTH +: PORT_WIDTH] = lfsr_d[k][PORT_WIDTH-1:0];
            end
          end else begin
            port_d = '0;
          end
          if (cnt_d == RUN_CYCLES) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= 32'd0;
      cnt_q        <= 32'd0;
      port_q       <= '0;
      cpu_resetb_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) lfsr_q[k] <= seed_of(k);
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      port_q       <= port_d;
      cpu_resetb_q <= (state_d == StPre) || (state_d == StRun) || (state_d == StDone);
      busy_q       <= (state_d == StPre) || (state_d == StAssert) || (state_d == StRun);
      done_q       <= (state_d == StDone);
    end
  end

  assign cpu_resetb = cpu_resetb_q;
  assign port_in    = port_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cycle_cnt  = cnt_q;

`ifdef YRV_STIM_IRQ_EN
  localparam logic [31:0] IrqLast = 32'(IRQ_PERIOD - 1);

  // Wrapping period counter avoids a modulo on cycle_cnt.
  logic [31:0] irq_cnt_q, irq_cnt_d;
  logic        ei_q, ei_d, nmi_q, nmi_d;

  always_comb begin
    irq_cnt_d = irq_cnt_q;
    ei_d      = 1'b0;
    nmi_d     = 1'b0;
    if (start_ok) begin
      irq_cnt_d = 32'd0;
    end else if (state_q == StRun && !hold) begin
      if (irq_cnt_q == IrqLast) begin
        ei_d      = 1'b1;
        irq_cnt_d = 32'd0;
      end else begin
        irq_cnt_d = irq_cnt_q + 32'd1;
      end
      nmi_d = (NMI_AT != 32'd0) && (cnt_d == NMI_AT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_cnt_q <= 32'd0;
      ei_q      <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      irq_cnt_q <= irq_cnt_d;
      ei_q      <= ei_d;
      nmi_q     <= nmi_d;
    end
  end

  assign ei_req  = ei_q;
  assign nmi_req = nmi_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_yrv_stim_seq.sv
// Randomized self-checking bench for yrv_stim_seq against a timeline-based reference model.
module tb_yrv_stim_seq;

  localparam int unsigned NP  = 2;
  localparam int unsigned PW  = 16;
  localparam int unsigned PRE = 10;
  localparam int unsigned RST = 10;
  localparam int unsigned RUN = 100;
  localparam int unsigned IRQ = 30;
  localparam int unsigned NMI = 45;

  logic              clk = 1'b0;
  logic              reset = 1'b0, start = 1'b0, rand_en = 1'b0, hold = 1'b0;
  logic              cpu_resetb, busy, done;
  logic [NP*PW-1:0]  port_in;
  logic [31:0]       cycle_cnt;
`ifdef YRV_STIM_IRQ_EN
  logic              ei_req, nmi_req;
  int unsigned       ei_seen = 0, nmi_seen = 0;
`endif

  yrv_stim_seq #(
    .NUM_PORTS (NP),
    .PORT_WIDTH(PW),
    .PRE_CYCLES(PRE),
    .RST_CYCLES(RST),
    .RUN_CYCLES(32'(RUN)),
    .SEED      (32'h1)
`ifdef YRV_STIM_IRQ_EN
    ,
    .IRQ_PERIOD(IRQ),
    .NMI_AT    (32'(NMI))
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rand_en   (rand_en),
    .hold      (hold),
    .cpu_resetb(cpu_resetb),
    .port_in   (port_in),
    .busy      (busy),
    .done      (done),
`ifdef YRV_STIM_IRQ_EN
    .ei_req    (ei_req),
    .nmi_req   (nmi_req),
`endif
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges since start define PRE/ASSERT phases, then a RUN step count.
  bit               m_active, m_done, m_ei, m_nmi;
  int unsigned      m_since, m_cnt;
  logic [31:0]      m_lfsr [NP];
  logic [NP*PW-1:0] m_port;

  function automatic logic [31:0] ref_seed(input int unsigned k);
    logic [31:0] s;
    s = 32'h1 + 32'(k) * 32'h9E3779B9;
    return (s == 0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  task automatic reload();
    for (int k = 0; k < NP; k++) m_lfsr[k] = ref_seed(k);
  endtask

  task automatic step(input bit s, input bit re, input bit h, input bit rst);
    start = s; rand_en = re; hold = h; reset = rst;
    @(posedge clk);
    m_ei = 0; m_nmi = 0;
    if (rst) begin
      m_active = 0; m_done = 0; m_cnt = 0; m_since = 0; m_port = '0; reload();
    end else if (!m_active) begin
      if (s) begin
        m_active = 1; m_done = 0; m_cnt = 0; m_since = 1; reload();
      end
    end else if (m_since <= PRE + RST) begin
      m_since++;
    end else if (!h) begin
      m_cnt++;
      if (re) begin
        for (int k = 0; k < NP; k++) begin
          m_lfsr[k] = ref_next(m_lfsr[k]);
          m_port[k*PW +: PW] = m_lfsr[k][PW-1:0];
        end
      end else begin
        m_port = '0;
      end
      m_ei  = (m_cnt % IRQ) == 0;
      m_nmi = (m_cnt == NMI);
      if (m_cnt == RUN) begin
        m_done = 1; m_active = 0;
      end
    end
    #1;
    check_eq("cpu_resetb", cpu_resetb,
             m_active ? !(m_since > PRE && m_since <= PRE + RST) : m_done);
    check_eq("busy", busy, m_active);
    check_eq("done", done, m_done);
    check_eq("cycle_cnt", cycle_cnt, m_cnt);
    check_eq("port_in", port_in, m_port);
`ifdef YRV_STIM_IRQ_EN
    check_eq("ei_req", ei_req, m_ei);
    check_eq("nmi_req", nmi_req, m_nmi);
    if (ei_req) ei_seen++;
    if (nmi_req) nmi_seen++;
`endif
  endtask

  // Start and walk through PRE/ASSERT with random (ignored) rand_en/hold.
  task automatic start_and_enter_run();
    step(1, 1, 0, 0);
    repeat (PRE + RST) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
  endtask

  task automatic check_first_values();
    step(0, 1, 0, 0);
    check_eq("ch0_cyc1", port_in[PW-1:0], 16'h0003);
    step(0, 1, 0, 0);
    check_eq("ch0_cyc2", port_in[PW-1:0], 16'h0002);
    check_eq("ch1_differs", port_in[PW-1:0] != port_in[2*PW-1:PW], 1);
  endtask

  int unsigned run_steps;

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (3) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Sequence timing, first LFSR values, hold pulse and done latency.
    start_and_enter_run();
    check_eq("run_entry_resetb", cpu_resetb, 1);
    check_first_values();
    run_steps = 2;
`ifdef YRV_STIM_IRQ_EN
    ei_seen = 0; nmi_seen = 0;
`endif
    for (int i = 0; i < 300 && !m_done; i++) begin
      step($urandom_range(0, 1), 1, (run_steps >= 40 && run_steps < 45), 0);
      run_steps++;
    end
    check_eq("run1_done", m_done, 1);
    check_eq("done_latency", run_steps, 105);
    check_eq("final_cnt", cycle_cnt, RUN);
`ifdef YRV_STIM_IRQ_EN
    check_eq("ei_count", ei_seen, 3);
    check_eq("nmi_count", nmi_seen, 1);
`endif
    repeat (4) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Restart from DONE, random traffic, reset at RUN cycle 50.
    step(1, 1, 0, 0);
    check_eq("restart_done_clr", done, 0);
    repeat (PRE + RST) step(0, 1, 0, 0);
    for (int i = 0; i < 300 && m_cnt < 50; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 0);
    check_eq("reached_50", m_cnt, 50);
    step(0, 1, 0, 1);
    check_eq("mid_reset_port", port_in, 0);
    repeat (2) step(0, 0, 0, 0);

    // Post-reset restart reproduces the same stream.
    start_and_enter_run();
    check_first_values();
    for (int i = 0; i < 300 && !m_done; i++) step(0, 1, 0, 0);
    check_eq("run2_done", m_done, 1);

    // rand_en=0 run keeps port_in at zero.
    step(1, 0, 0, 0);
    repeat (PRE + RST) step(0, 0, 0, 0);
    for (int i = 0; i < 300 && !m_done; i++) begin
      step(0, 0, $urandom_range(0, 4) == 0, 0);
      check_eq("port_zero", port_in, 0);
    end
    check_eq("run3_done", m_done, 1);

    // Fully random run.
    start_and_enter_run();
    for (int i = 0; i < 400 && !m_done; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0, 0);
    check_eq("run4_done", m_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
